// File: rtl/alu_fwd_ctrl.sv
// rtl/alu_fwd_ctrl.sv - ALU forwarding/hazard controller; optional stall counter under SAIL_FWD_STALL_COUNT_EN
module alu_fwd_ctrl #(
  parameter int ALU_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_rs1_used,
  input  logic        issue_rs2_used,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        flush,
  output logic        stall,
`ifdef SAIL_FWD_STALL_COUNT_EN
  output logic [31:0] stall_count,
`endif
  output logic        MEM_fwd1_reg,
  output logic        MEM_fwd2_reg,
  output logic        WB_fwd1_reg,
  output logic        WB_fwd2_reg
);

  // Per-source classification of the youngest matching producer.
  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_HAZ  = 2'd1;
  localparam logic [1:0] CLS_MEM  = 2'd2;
  localparam logic [1:0] CLS_WB   = 2'd3;

  // Index ALU_LAT-2 means the result reaches MEM exactly when the consumer samples operands.
  localparam int MEM_IDX = ALU_LAT - 2;

  logic [ALU_LAT-1:0] p_valid;
  logic [4:0]         p_rd [ALU_LAT];
  logic [1:0]         cls1;
  logic [1:0]         cls2;
  logic               accept;

  // Scan oldest to youngest so the smallest matching index overwrites older matches.
  always_comb begin
    cls1 = CLS_NONE;
    cls2 = CLS_NONE;
    for (int i = ALU_LAT - 1; i >= 0; i--) begin
      if (p_valid[i] && (p_rd[i] == issue_rs1) && (issue_rs1 != 5'd0) && issue_rs1_used) begin
        if (i < MEM_IDX)       cls1 = CLS_HAZ;
        else if (i == MEM_IDX) cls1 = CLS_MEM;
        else                   cls1 = CLS_WB;
      end
      if (p_valid[i] && (p_rd[i] == issue_rs2) && (issue_rs2 != 5'd0) && issue_rs2_used) begin
        if (i < MEM_IDX)       cls2 = CLS_HAZ;
        else if (i == MEM_IDX) cls2 = CLS_MEM;
        else                   cls2 = CLS_WB;
      end
    end
  end

  // Handshake: flush blocks issue, and any operand still inside the ALU blocks issue.
  always_comb begin
    issue_ready = ~flush & (cls1 != CLS_HAZ) & (cls2 != CLS_HAZ);
    stall       = issue_valid & ~issue_ready;
    accept      = issue_valid & issue_ready;
  end

  // Tag pipe shift; flush kills producers whose results have not yet been committed to MEM/WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= '0;
      for (int i = 0; i < ALU_LAT; i++) p_rd[i] <= 5'd0;
    end else begin
      p_valid[0] <= accept & issue_rd_we & (issue_rd != 5'd0);
      p_rd[0]    <= issue_rd;
      for (int i = 1; i < ALU_LAT; i++) begin
        p_valid[i] <= p_valid[i-1] & ~(flush & (i <= ALU_LAT - 2));
        p_rd[i]    <= p_rd[i-1];
      end
    end
  end

  // Registered forward selects, aligned with the ALU operand-capture cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_fwd1_reg <= 1'b0;
      MEM_fwd2_reg <= 1'b0;
      WB_fwd1_reg  <= 1'b0;
      WB_fwd2_reg  <= 1'b0;
    end else begin
      MEM_fwd1_reg <= accept & (cls1 == CLS_MEM);
      MEM_fwd2_reg <= accept & (cls2 == CLS_MEM);
      WB_fwd1_reg  <= accept & (cls1 == CLS_WB);
      WB_fwd2_reg  <= accept & (cls2 == CLS_WB);
    end
  end

`ifdef SAIL_FWD_STALL_COUNT_EN
  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                                 stall_count <= 32'd0;
    else if (stall && (stall_count != '1))   stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_fwd_ctrl.sv
// tb/tb_alu_fwd_ctrl.sv - scoreboard bench for alu_fwd_ctrl
module tb_alu_fwd_ctrl;
  localparam int ALU_LAT = 5;
  localparam int NCYC    = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [4:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic       issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, issue_rd_we = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic       MEM_fwd1_reg, MEM_fwd2_reg, WB_fwd1_reg, WB_fwd2_reg;
`ifdef SAIL_FWD_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  alu_fwd_ctrl #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .flush(flush), .stall(stall),
`ifdef SAIL_FWD_STALL_COUNT_EN
    .stall_count(stall_count),
`endif
    .MEM_fwd1_reg(MEM_fwd1_reg), .MEM_fwd2_reg(MEM_fwd2_reg),
    .WB_fwd1_reg(WB_fwd1_reg), .WB_fwd2_reg(WB_fwd2_reg)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: producer record per issue cycle; results reach MEM at accept+ALU_LAT.
  bit         pv  [NCYC];
  logic [4:0] prd [NCYC];
  int         cyc = 0;
  logic [31:0] model_sc = 0;
  logic [3:0] exp_q[$];
  bit         started = 0;
  bit         mon_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer accepted at c samples operands at c+1: needs MEM when age==ALU_LAT-1, WB when age==ALU_LAT.
  function automatic int classify(input int c, input logic [4:0] s, input logic used);
    int a;
    if (!used || s == 5'd0) return 0;
    for (int d = 1; d <= ALU_LAT; d++) begin
      a = c - d;
      if (a >= 0 && pv[a] && prd[a] == s) begin
        if (d <= ALU_LAT - 2)      return 1;
        else if (d == ALU_LAT - 1) return 2;
        else                       return 3;
      end
    end
    return 0;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic we, input logic fl, output logic acc, output logic dut_stall);
    int c1, c2;
    logic er;
    @(posedge clk); #1;
`ifdef SAIL_FWD_STALL_COUNT_EN
    check("stall_count", stall_count, model_sc);
`endif
    rst = 1'b0;
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_rs1_used = u1; issue_rs2_used = u2;
    issue_rd = rd; issue_rd_we = we; flush = fl;
    #1;
    c1 = classify(cyc, rs1, u1);
    c2 = classify(cyc, rs2, u2);
    er = !fl && c1 != 1 && c2 != 1;
    check("issue_ready", {31'd0, issue_ready}, {31'd0, er});
    check("stall", {31'd0, stall}, {31'd0, v & ~er});
    dut_stall = stall;
    acc = v & er;
    if (v && !er && model_sc != 32'hFFFFFFFF) model_sc = model_sc + 1;
    if (acc) exp_q.push_back({c1 == 2, c2 == 2, c1 == 3, c2 == 3});
    pv[cyc]  = acc && we && rd != 5'd0;
    prd[cyc] = rd;
    if (fl) for (int a = cyc - (ALU_LAT - 2); a < cyc; a++) if (a >= 0) pv[a] = 0;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; issue_valid = 1'b0; flush = 1'b0;
    issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_rd_we = 1'b0;
    for (int a = 0; a < NCYC; a++) pv[a] = 0;
    model_sc = 0;
    started = 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic a, s;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, a, s);
  endtask

  // Monitor: latch DUT handshakes, then compare forward selects in the following cycle.
  always @(posedge clk) mon_acc <= !rst && issue_valid && issue_ready;

  always @(negedge clk) begin
    if (started) begin
      if (mon_acc) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fwd_unexpected_accept actual=accept required=none (cycle %0d)", cyc);
        end else begin
          check("fwd", {28'd0, MEM_fwd1_reg, MEM_fwd2_reg, WB_fwd1_reg, WB_fwd2_reg},
                {28'd0, exp_q.pop_front()});
        end
      end else begin
        check("fwd_idle", {28'd0, MEM_fwd1_reg, MEM_fwd2_reg, WB_fwd1_reg, WB_fwd2_reg}, 32'd0);
      end
    end
  end

  initial begin
    logic a, s;
    int nst;
    do_reset();

    // Back-to-back dependency: stall ALU_LAT-2 cycles, then MEM forward on operand A.
    step(1, 0, 0, 0, 0, 5, 1, 0, a, s);
    nst = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 5, 0, 1, 0, 0, 0, 0, a, s);
      if (s) nst++;
      if (a) break;
    end
    check("s1_stall_cycles", nst, ALU_LAT - 2);
    idle(6);

    // Distance ALU_LAT: WB forward on operand B.
    step(1, 0, 0, 0, 0, 7, 1, 0, a, s);
    for (int k = 0; k < 4; k++) step(1, 20, 21, 1, 1, 5'(10 + k), 1, 0, a, s);
    step(1, 1, 7, 0, 1, 0, 0, 0, a, s);
    idle(6);

    // x0 never produces a dependency.
    step(1, 0, 0, 0, 0, 0, 1, 0, a, s);
    step(1, 0, 0, 1, 1, 0, 0, 0, a, s);
    idle(6);

    // Two producers of x9: the younger one wins, MEM on both operands.
    step(1, 0, 0, 0, 0, 9, 1, 0, a, s);
    step(1, 0, 0, 0, 0, 9, 1, 0, a, s);
    idle(3);
    step(1, 9, 9, 1, 1, 0, 0, 0, a, s);
    idle(6);

    // Flush kills a young producer; the consumer issues without stall.
    step(1, 0, 0, 0, 0, 3, 1, 0, a, s);
    idle(1);
    step(1, 4, 4, 1, 1, 0, 0, 1, a, s);
    step(1, 3, 0, 1, 0, 0, 0, 0, a, s);
    idle(6);

    // Reset during a stall discards tags.
    step(1, 0, 0, 0, 0, 6, 1, 0, a, s);
    step(1, 6, 0, 1, 0, 0, 0, 0, a, s);
    step(1, 6, 0, 1, 0, 0, 0, 0, a, s);
    do_reset();
    step(1, 6, 0, 1, 0, 0, 0, 0, a, s);
    idle(6);

    // Random traffic over a small register set to exercise every classification.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                $urandom_range(0, 19) == 0, a, s);
    end
    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
